// File: rtl/instr_issue_pkg.sv
// instr_pkg -- shared definitions for the instruction issue block.
//   * state_t        : issue FSM states
//   * *_HI / *_LO    : bit positions of the MIPS instruction fields
//   * CTRL_*         : bit indices inside the 6-bit CONTROL word from the decoder
//   * ALU_OP_MUL     : ALU_OPCODE value that selects the multi-cycle multiplier
//   * flags_of()     : registered status outputs that belong to a given state
package instr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_MUL_HOLD,
        ST_HALT
    } state_t;

    // MIPS field positions
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // CONTROL bit indices
    localparam int CTRL_CE_MEM     = 0;
    localparam int CTRL_ALU_LO     = 1;
    localparam int CTRL_ALU_HI     = 2;
    localparam int CTRL_SEL_OPERAB = 3;
    localparam int CTRL_REG_WR     = 4;
    localparam int CTRL_SEL_DEST   = 5;

    localparam logic [1:0] ALU_OP_MUL = 2'b10;

    // Status outputs are a pure function of the state being entered, so the
    // FSM loads them together with the state register.
    typedef struct packed {
        logic req;
        logic hab;
        logic busy;
        logic halted;
    } state_flags_t;

    function automatic state_flags_t flags_of(input state_t s);
        state_flags_t f;
        f.req    = (s == ST_FETCH);
        f.hab    = (s == ST_ISSUE) || (s == ST_MUL_HOLD);
        f.busy   = (s != ST_IDLE) && (s != ST_HALT);
        f.halted = (s == ST_HALT);
        return f;
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// instr_issue_if -- instruction-memory read port.
//   IMEM_REQ  : read request, held until acknowledged
//   IMEM_ADDR : word address (ADDR_W bits)
//   IMEM_ACK  : one-cycle pulse, IMEM_DATA valid in that cycle
//   IMEM_DATA : 32-bit instruction word
// master = issue unit, slave = instruction memory.
interface instr_issue_if #(
    parameter int ADDR_W = 8
);
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_ACK;
    logic [31:0]       IMEM_DATA;

    modport master (output IMEM_REQ, IMEM_ADDR, input IMEM_ACK, IMEM_DATA);
    modport slave  (input IMEM_REQ, IMEM_ADDR, output IMEM_ACK, IMEM_DATA);
endinterface

// File: rtl/instr_issue_fields.sv
// instr_fields -- registered splitter of a MIPS instruction word.
//   clk, srst : clock, synchronous active-high reset (clears all fields)
//   load      : capture data on this edge; otherwise fields hold
//   data      : 32-bit instruction word
//   op_code, funct, rs, rt, rd, imm16 : registered fields
module instr_fields
    import instr_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [31:0] data,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16
);

    always_ff @(posedge clk) begin
        if (srst) begin
            op_code <= '0;
            funct   <= '0;
            rs      <= '0;
            rt      <= '0;
            rd      <= '0;
            imm16   <= '0;
        end else if (load) begin
            op_code <= data[OP_HI:OP_LO];
            funct   <= data[FUNCT_HI:FUNCT_LO];
            rs      <= data[RS_HI:RS_LO];
            rt      <= data[RT_HI:RT_LO];
            rd      <= data[RD_HI:RD_LO];
            imm16   <= data[IMM_HI:IMM_LO];
        end
    end

endmodule

// File: rtl/instr_issue.sv
// instr_issue -- sequential fetch/issue unit for MIPS-format instructions.
// Fetches words from PC=0 up to PC_LAST, hands the decoded fields to an
// external control decoder (HAB), holds the pipeline for multi-cycle
// multiplies, then halts until reset.
//   CLK, RESET  : clock, synchronous active-high reset
//   START       : level, starts a program run from IDLE
//   imem        : instruction-memory read port (instr_issue_if.master)
//   OP_CODE, FUNCT, RS, RT, RD, IMM16 : registered instruction fields
//   HAB         : decoder enable (ISSUE and MUL_HOLD)
//   CONTROL     : decoder output, sampled combinationally in ISSUE
//   ISSUED      : pulse in the last cycle of an instruction's issue
//   BUSY, HALTED: run status
//   ILLEGAL     : sticky illegal-instruction flag
// Build option: define ILLEGAL_TRAP_EN to trap an all-zero CONTROL word
// (sets ILLEGAL and halts at the trapping PC). Without it a zero CONTROL is
// a NOP and ILLEGAL is constant 0.
module instr_issue
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MUL_CYCLES = 3,
    parameter int PC_LAST    = 2**ADDR_W - 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    instr_issue_if.master imem,
    output logic [5:0]   OP_CODE,
    output logic [5:0]   FUNCT,
    output logic [4:0]   RS,
    output logic [4:0]   RT,
    output logic [4:0]   RD,
    output logic [15:0]  IMM16,
    output logic         HAB,
    input  logic [5:0]   CONTROL,
    output logic         ISSUED,
    output logic         BUSY,
    output logic         HALTED,
    output logic         ILLEGAL
);

    localparam logic [ADDR_W-1:0] PC_END    = ADDR_W'(PC_LAST);
    localparam bit                MUL_MULTI = (MUL_CYCLES > 1);
    localparam int                MUL_LOAD_I = MUL_MULTI ? (MUL_CYCLES - 2) : 0;
    localparam logic [3:0]        MUL_LOAD  = 4'(MUL_LOAD_I);

    state_t            state_reg;
    state_flags_t      flags_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [3:0]        mul_cnt_reg;

    logic              is_mul;
    logic              trap_now;
    logic              at_last;
    state_t            adv_state;
    logic [ADDR_W-1:0] pc_adv;
    logic              unused_ctrl;

    // Only the ALU opcode steers the issue unit; the remaining decoder bits
    // matter only for the zero-word trap.
    assign unused_ctrl = ^{CONTROL[CTRL_CE_MEM], CONTROL[CTRL_SEL_OPERAB],
                           CONTROL[CTRL_REG_WR], CONTROL[CTRL_SEL_DEST]};

    assign is_mul = MUL_MULTI && (CONTROL[CTRL_ALU_HI:CTRL_ALU_LO] == ALU_OP_MUL);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;
    assign trap_now = (state_reg == ST_ISSUE) && (CONTROL == 6'b000000);
    assign ILLEGAL  = illegal_reg;
`else
    assign trap_now = 1'b0;
    assign ILLEGAL  = 1'b0;
`endif

    // PC never wraps: the last address halts instead of incrementing.
    assign at_last   = (pc_reg == PC_END);
    assign adv_state = at_last ? ST_HALT : ST_FETCH;
    assign pc_adv    = at_last ? pc_reg : pc_reg + ADDR_W'(1);

    // ISSUED depends on CONTROL in the ISSUE cycle, so it cannot be a flop.
    assign ISSUED = ((state_reg == ST_ISSUE) && !trap_now && !is_mul) ||
                    ((state_reg == ST_MUL_HOLD) && (mul_cnt_reg == 4'd0));

    assign imem.IMEM_REQ  = flags_reg.req;
    assign imem.IMEM_ADDR = pc_reg;
    assign HAB            = flags_reg.hab;
    assign BUSY           = flags_reg.busy;
    assign HALTED         = flags_reg.halted;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            flags_reg   <= '0;
            pc_reg      <= '0;
            mul_cnt_reg <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (START) begin
                        pc_reg    <= '0;
                        state_reg <= ST_FETCH;
                        flags_reg <= flags_of(ST_FETCH);
                    end
                end
                ST_FETCH: begin
                    if (imem.IMEM_ACK) begin
                        state_reg <= ST_ISSUE;
                        flags_reg <= flags_of(ST_ISSUE);
                    end
                end
                ST_ISSUE: begin
                    if (trap_now) begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_reg <= 1'b1;
`endif
                        state_reg <= ST_HALT;
                        flags_reg <= flags_of(ST_HALT);
                    end else if (is_mul) begin
                        mul_cnt_reg <= MUL_LOAD;
                        state_reg   <= ST_MUL_HOLD;
                        flags_reg   <= flags_of(ST_MUL_HOLD);
                    end else begin
                        pc_reg    <= pc_adv;
                        state_reg <= adv_state;
                        flags_reg <= flags_of(adv_state);
                    end
                end
                ST_MUL_HOLD: begin
                    if (mul_cnt_reg == 4'd0) begin
                        pc_reg    <= pc_adv;
                        state_reg <= adv_state;
                        flags_reg <= flags_of(adv_state);
                    end else begin
                        mul_cnt_reg <= mul_cnt_reg - 4'd1;
                    end
                end
                ST_HALT: begin
                    // Only RESET leaves HALT.
                end
                default: begin
                    state_reg <= ST_IDLE;
                    flags_reg <= flags_of(ST_IDLE);
                end
            endcase
        end
    end

    // Fields load only on an acknowledged fetch; stray ACKs are ignored.
    instr_fields u_fields (
        .clk     (CLK),
        .srst    (RESET),
        .load    ((state_reg == ST_FETCH) && imem.IMEM_ACK),
        .data    (imem.IMEM_DATA),
        .op_code (OP_CODE),
        .funct   (FUNCT),
        .rs      (RS),
        .rt      (RT),
        .rd      (RD),
        .imm16   (IMM16)
    );

endmodule
